// File: rtl/register_same_cycle_rw.sv
// Single-word architectural register with same-cycle write forwarding.
// A write shows on rdata in the same cycle and is committed to storage at the next rising edge.
module register_same_cycle_rw #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               BYPASS      = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= RESET_VALUE;
      end else if (wr) begin
         q <= wdata;
      end
   end

   // Reset dominates forwarding, so rdata is clean the moment reset falls.
   always_comb begin
      rdata = q;
      if (!reset) begin
         rdata = RESET_VALUE;
      end else if (BYPASS && wr) begin
         rdata = wdata;
      end
   end

endmodule

// File: tb/tb_register_same_cycle_rw.sv
// Bench for register_same_cycle_rw: a forwarding instance and a storage-only instance
// with reset value all-ones share one stimulus stream.
`timescale 1ns/1ps
module tb_register_same_cycle_rw;
   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         wr;
   logic [W-1:0] wdata;
   logic [W-1:0] rdata_a;
   logic [W-1:0] rdata_b;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int           t;
      logic         rst;
      logic         wr;
      logic [W-1:0] wd;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
   } vec_t;

   typedef struct {
      string        name;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
   } exp_t;

   vec_t rows[$];
   exp_t sb[$];

   register_same_cycle_rw #(
      .WIDTH(W), .RESET_VALUE(32'h0000_0000), .BYPASS(1'b1)
   ) dut_a (
      .clk(clk), .reset(reset), .wr(wr), .wdata(wdata), .rdata(rdata_a)
   );

   register_same_cycle_rw #(
      .WIDTH(W), .RESET_VALUE(32'hffff_ffff), .BYPASS(1'b0)
   ) dut_b (
      .clk(clk), .reset(reset), .wr(wr), .wdata(wdata), .rdata(rdata_b)
   );

   // Rising edges at 10, 30, 50, ... ; falling edges at 20, 40, ...
   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic void add(int t, logic r, logic w, logic [W-1:0] d,
                               logic [W-1:0] ea, logic [W-1:0] eb);
      vec_t v;
      v.t = t; v.rst = r; v.wr = w; v.wd = d; v.ea = ea; v.eb = eb;
      rows.push_back(v);
   endfunction

   task automatic drive(input string name, input logic r, input logic w,
                        input logic [W-1:0] d, input logic [W-1:0] ea,
                        input logic [W-1:0] eb);
      exp_t e;
      reset = r;
      wr    = w;
      wdata = d;
      e.name = name; e.ea = ea; e.eb = eb;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: no expected entry queued");
         return;
      end
      e = sb.pop_front();
      checks++;
      if (rdata_a !== e.ea) begin
         errors++;
         $display("FAIL %s bypass: rdata=%h expected %h", e.name, rdata_a, e.ea);
      end
      checks++;
      if (rdata_b !== e.eb) begin
         errors++;
         $display("FAIL %s nobypass: rdata=%h expected %h", e.name, rdata_b, e.eb);
      end
   endtask

   initial begin
      logic [W-1:0] prev;
      logic [W-1:0] d;

      reset = 1'b0;
      wr    = 1'b0;
      wdata = '0;

      //  time rst wr wdata          exp bypass     exp no-bypass
      add(  0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'hffff_ffff); // power-up, before any edge
      add( 12, 0, 1, 32'h0000_5555, 32'h0000_0000, 32'hffff_ffff); // write during reset discarded
      add( 22, 1, 0, 32'h0000_0000, 32'h0000_0000, 32'hffff_ffff); // release between edges
      add( 32, 1, 0, 32'h0000_0000, 32'h0000_0000, 32'hffff_ffff); // idle edge, nothing written
      add( 42, 1, 1, 32'h0000_abcd, 32'h0000_abcd, 32'hffff_ffff); // same-cycle forward
      add( 52, 1, 1, 32'h0000_abcd, 32'h0000_abcd, 32'h0000_abcd); // wr held across edge
      add( 62, 1, 0, 32'h0000_0000, 32'h0000_abcd, 32'h0000_abcd); // wr dropped, stored
      add( 64, 0, 1, 32'h0000_abcd, 32'h0000_0000, 32'hffff_ffff); // mid-cycle reset
      add( 72, 0, 1, 32'h0000_abcd, 32'h0000_0000, 32'hffff_ffff); // reset across edge, wr=1
      add( 82, 1, 0, 32'h0000_0000, 32'h0000_0000, 32'hffff_ffff); // storage was cleared
      add( 85, 1, 1, 32'h0000_1234, 32'h0000_1234, 32'hffff_ffff); // pulse spanning edge 90
      add( 95, 1, 0, 32'hxxxx_xxxx, 32'h0000_1234, 32'h0000_1234); // X wdata while idle
      add(105, 1, 1, 32'h0000_cdef, 32'h0000_cdef, 32'h0000_1234);
      add(115, 1, 0, 32'hxxxx_xxxx, 32'h0000_cdef, 32'h0000_cdef);
      add(135, 1, 0, 32'hxxxx_xxxx, 32'h0000_cdef, 32'h0000_cdef); // idle cycle holds
      add(145, 1, 1, 32'h0000_beef, 32'h0000_beef, 32'h0000_cdef);
      add(155, 1, 0, 32'hxxxx_xxxx, 32'h0000_beef, 32'h0000_beef);
      add(165, 1, 1, 32'h0000_2424, 32'h0000_2424, 32'h0000_beef);
      add(175, 1, 0, 32'hxxxx_xxxx, 32'h0000_2424, 32'h0000_2424);
      add(181, 1, 1, 32'hdead_beef, 32'hdead_beef, 32'h0000_2424); // pulse misses any edge
      add(186, 1, 0, 32'hxxxx_xxxx, 32'h0000_2424, 32'h0000_2424); // reverts before edge
      add(192, 1, 0, 32'h0000_0000, 32'h0000_2424, 32'h0000_2424); // storage unchanged
      add(202, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'hffff_ffff); // final reset
      add(212, 1, 1, 32'h0000_0077, 32'h0000_0077, 32'hffff_ffff); // first write after release
      add(232, 1, 0, 32'h0000_0000, 32'h0000_0077, 32'h0000_0077);

      foreach (rows[i]) begin
         while ($time < rows[i].t) #1;
         drive($sformatf("row%0d", i), rows[i].rst, rows[i].wr, rows[i].wd,
               rows[i].ea, rows[i].eb);
         #1;
         check_out();
      end

      // Back-to-back writes: every edge captures that cycle's data.
      prev = 32'h0000_0077;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         d = $urandom;
         drive($sformatf("b2b%0d", k), 1'b1, 1'b1, d, d, prev);
         #1;
         check_out();
         prev = d;
      end
      @(negedge clk);
      #1;
      drive("b2b_end", 1'b1, 1'b0, 32'h0, prev, prev);
      #1;
      check_out();

      @(negedge clk);
      #1;
      drive("b2b_reset", 1'b0, 1'b1, 32'h1357_9bdf, 32'h0000_0000, 32'hffff_ffff);
      #1;
      check_out();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
